// File: rtl/pit_if.sv
// pit_if: interest, FIB-query and payload signals of the pending interest table.
interface pit_if #(parameter int ENTRIES = 16);
    logic                      int_valid;
    logic [63:0]               int_prefix;
    logic [5:0]                int_len;
    logic                      int_ready;
    logic                      int_drop;
    logic                      int_aggregated;
    logic                      fib_out_bit;
    logic [63:0]               pit_in_prefix;
    logic [5:0]                pit_in_len;
    logic                      prefix_ready;
    logic [63:0]               fib_prefix;
    logic [5:0]                fib_len;
    logic                      rejected;
    logic                      start_send_to_pit;
    logic [7:0]                fib_data;
    logic [7:0]                data_out;
    logic                      data_out_valid;
    logic                      data_last;
    logic [$clog2(ENTRIES):0]  occupancy;
    modport slave (
        input  int_valid, int_prefix, int_len, prefix_ready, fib_prefix, fib_len, fib_data,
        output int_ready, int_drop, int_aggregated, fib_out_bit, pit_in_prefix, pit_in_len,
               rejected, start_send_to_pit, data_out, data_out_valid, data_last, occupancy
    );
    modport master (
        output int_valid, int_prefix, int_len, prefix_ready, fib_prefix, fib_len, fib_data,
        input  int_ready, int_drop, int_aggregated, fib_out_bit, pit_in_prefix, pit_in_len,
               rejected, start_send_to_pit, data_out, data_out_valid, data_last, occupancy
    );
endinterface

// File: rtl/pit_table.sv
// pit_table: NDN pending interest table; records/aggregates interests, answers FIB
// data queries and streams the payload of accepted queries downstream.
module pit_table #(
    parameter int ENTRIES    = 16,
    parameter int DATA_BYTES = 1024,
    parameter int LIFETIME   = 4096
) (
    input logic clk,
    input logic rst,
    pit_if.slave bus
);
    localparam int IW = $clog2(ENTRIES);
    localparam int LW = $clog2(LIFETIME + 1);
    localparam logic [10:0] LAST = 11'(DATA_BYTES - 1);
    typedef enum logic {I_IDLE, I_LOOK} i_state_t;
    typedef enum logic [1:0] {D_IDLE, D_LOOK, D_RESP, D_XFER} d_state_t;
    i_state_t           i_state;
    d_state_t           d_state;
    logic [ENTRIES-1:0] valid, busy, int_hit, q_hit, alloc_mask, claim_mask, retire_mask;
    logic [63:0]        prefix [ENTRIES];
    logic [5:0]         len [ENTRIES];
    logic [LW-1:0]      life [ENTRIES];
    logic [63:0]        q_prefix;
    logic [5:0]         q_len;
    logic [IW-1:0]      free_idx, hit_idx, cur_idx;
    logic               free_any, q_any, int_match, alloc;
    logic [10:0]        cnt;
    logic [IW:0]        count;

    always_comb begin
        int_hit = '0;
        q_hit = '0;
        free_idx = '0;
        hit_idx = '0;
        free_any = 1'b0;
        q_any = 1'b0;
        count = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            int_hit[i] = valid[i] && len[i] == bus.int_len && prefix[i] == bus.int_prefix;
            q_hit[i] = valid[i] && len[i] == q_len && prefix[i] == q_prefix;
            if (!valid[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            if (q_hit[i]) begin
                q_any = 1'b1;
                hit_idx = IW'(i);
            end
            count = count + (IW+1)'(valid[i]);
        end
    end

    // The interest lookup happens on the handshake edge so its outcome pulse lands in I_LOOK.
    assign int_match   = |int_hit;
    assign alloc       = i_state == I_IDLE && bus.int_valid && !int_match && free_any;
    assign alloc_mask  = alloc ? ENTRIES'(1) << free_idx : '0;
    assign claim_mask  = (d_state == D_LOOK && q_any) ? ENTRIES'(1) << hit_idx : '0;
    assign retire_mask = (d_state == D_XFER && cnt == LAST) ? ENTRIES'(1) << cur_idx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            busy <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                prefix[i] <= '0;
                len[i] <= '0;
                life[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (alloc_mask[i]) begin
                    valid[i] <= 1'b1;
                    busy[i] <= 1'b0;
                    prefix[i] <= bus.int_prefix;
                    len[i] <= bus.int_len;
                    life[i] <= LW'(LIFETIME);
                end else if (retire_mask[i]) begin
                    valid[i] <= 1'b0;
                    busy[i] <= 1'b0;
                end else if (claim_mask[i]) begin
                    busy[i] <= 1'b1;
                end else if (valid[i] && !busy[i]) begin
                    if (life[i] == LW'(1)) valid[i] <= 1'b0;
                    else life[i] <= life[i] - LW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state <= I_IDLE;
            bus.int_ready <= 1'b1;
            bus.int_drop <= 1'b0;
            bus.int_aggregated <= 1'b0;
            bus.fib_out_bit <= 1'b0;
            bus.pit_in_prefix <= '0;
            bus.pit_in_len <= '0;
        end else begin
            bus.int_drop <= 1'b0;
            bus.int_aggregated <= 1'b0;
            bus.fib_out_bit <= 1'b0;
            if (i_state == I_IDLE) begin
                if (bus.int_valid) begin
                    i_state <= I_LOOK;
                    bus.int_ready <= 1'b0;
                    bus.int_aggregated <= int_match;
                    bus.fib_out_bit <= alloc;
                    bus.int_drop <= !int_match && !free_any;
                    if (alloc) begin
                        bus.pit_in_prefix <= bus.int_prefix;
                        bus.pit_in_len <= bus.int_len;
                    end
                end
            end else begin
                i_state <= I_IDLE;
                bus.int_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state <= D_IDLE;
            q_prefix <= '0;
            q_len <= '0;
            cur_idx <= '0;
            cnt <= '0;
            bus.rejected <= 1'b0;
            bus.start_send_to_pit <= 1'b0;
            bus.data_out <= '0;
            bus.data_out_valid <= 1'b0;
            bus.data_last <= 1'b0;
            bus.occupancy <= '0;
        end else begin
            bus.occupancy <= count;
            bus.rejected <= 1'b0;
            bus.start_send_to_pit <= 1'b0;
            bus.data_out_valid <= 1'b0;
            bus.data_last <= 1'b0;
            case (d_state)
                D_IDLE: if (bus.prefix_ready) begin
                    q_prefix <= bus.fib_prefix;
                    q_len <= bus.fib_len;
                    d_state <= D_LOOK;
                end
                D_LOOK: begin
                    cur_idx <= hit_idx;
                    bus.start_send_to_pit <= q_any;
                    bus.rejected <= !q_any;
                    d_state <= D_RESP;
                end
                D_RESP: begin
                    cnt <= '0;
                    d_state <= bus.start_send_to_pit ? D_XFER : D_IDLE;
                end
                D_XFER: begin
                    bus.data_out <= bus.fib_data;
                    bus.data_out_valid <= 1'b1;
                    bus.data_last <= cnt == LAST;
                    cnt <= cnt + 11'd1;
                    if (cnt == LAST) d_state <= D_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pit_table.sv
// tb_pit_table: directed checks of interest recording, aggregation, drop, query
// responses, payload streaming, lifetime expiry and reset mid-transfer.
module tb_pit_table;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    localparam logic [63:0] PA = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] PX = 64'h0000_0000_CAFE_F00D;
    localparam logic [63:0] PY = 64'hBEEF_0000_0000_0001;

    pit_if #(.ENTRIES(16)) bus ();
    pit_table #(.ENTRIES(16), .DATA_BYTES(1024), .LIFETIME(4096)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'((k * 7 + 3) & 255);
    endfunction

    // Starts at a negedge; returns at the negedge of the outcome cycle (T+1).
    task automatic interest(input logic [63:0] p, input logic [5:0] l);
        bus.int_valid = 1'b1;
        bus.int_prefix = p;
        bus.int_len = l;
        @(negedge clk);
        bus.int_valid = 1'b0;
    endtask

    // Starts at a negedge; returns at the negedge of the response cycle (T+2).
    task automatic query(input logic [63:0] p, input logic [5:0] l);
        bus.prefix_ready = 1'b1;
        bus.fib_prefix = p;
        bus.fib_len = l;
        @(negedge clk);
        bus.prefix_ready = 1'b0;
        chk("resp_not_early", {62'b0, bus.rejected, bus.start_send_to_pit}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        bus.int_valid = 1'b0;
        bus.int_prefix = '0;
        bus.int_len = '0;
        bus.prefix_ready = 1'b0;
        bus.fib_prefix = '0;
        bus.fib_len = '0;
        bus.fib_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_int_ready", bus.int_ready, 1);
        chk("rst_fib_out_bit", bus.fib_out_bit, 0);
        chk("rst_pulses", {bus.int_drop, bus.int_aggregated, bus.rejected, bus.start_send_to_pit}, 0);
        chk("rst_data", {bus.data_out_valid, bus.data_last, bus.data_out}, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_pit_in", {bus.pit_in_len, bus.pit_in_prefix[57:0]}, 0);
        @(negedge clk);
        interest(PA, 6'd12);
        chk("new_fib_out_bit", bus.fib_out_bit, 1);
        chk("new_no_agg_drop", {bus.int_aggregated, bus.int_drop}, 0);
        chk("new_pit_in_prefix", bus.pit_in_prefix, PA);
        chk("new_pit_in_len", bus.pit_in_len, 12);
        chk("look_not_ready", bus.int_ready, 0);
        @(negedge clk);
        chk("fib_out_bit_pulse", bus.fib_out_bit, 0);
        chk("ready_again", bus.int_ready, 1);
        chk("occ_after_alloc", bus.occupancy, 1);
        interest(PA, 6'd12);
        chk("dup_aggregated", bus.int_aggregated, 1);
        chk("dup_no_fib_out", bus.fib_out_bit, 0);
        chk("dup_pit_in_held", bus.pit_in_prefix, PA);
        @(negedge clk);
        chk("dup_occ", bus.occupancy, 1);
        for (int i = 1; i < 16; i++) begin
            interest((64'(i) << 8) | 64'h11, 6'(i));
            chk("fill_fib_out_bit", bus.fib_out_bit, 1);
            @(negedge clk);
        end
        chk("full_occ", bus.occupancy, 16);
        interest(64'hDEAD, 6'd5);
        chk("full_drop", bus.int_drop, 1);
        chk("full_no_fwd", {bus.fib_out_bit, bus.int_aggregated}, 0);
        @(negedge clk);
        chk("drop_pulse", bus.int_drop, 0);
        chk("drop_occ", bus.occupancy, 16);
        query(PA, 6'd12);
        chk("hit_start", bus.start_send_to_pit, 1);
        chk("hit_not_rejected", bus.rejected, 0);
        @(negedge clk);
        bus.fib_data = pat(0);
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            chk("xfer_byte", {bus.data_out_valid, bus.data_out}, {55'd0, 1'b1, pat(k)});
            chk("xfer_last", bus.data_last, k == 1023);
            bus.fib_data = pat(k + 1);
        end
        @(negedge clk);
        chk("xfer_done_valid", {bus.data_out_valid, bus.data_last}, 0);
        chk("xfer_done_occ", bus.occupancy, 15);
        query(64'h1234, 6'd3);
        chk("miss_rejected", bus.rejected, 1);
        chk("miss_no_start", bus.start_send_to_pit, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("miss_no_data", {bus.data_out_valid, bus.rejected}, 0);
        end
        query((64'd1 << 8) | 64'h11, 6'd2);
        chk("len_mismatch_rejected", bus.rejected, 1);
        @(negedge clk);
        chk("miss_occ", bus.occupancy, 15);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_occ", bus.occupancy, 0);
        interest(PX, 6'd20);
        chk("life_alloc", bus.fib_out_bit, 1);
        repeat (4096) @(negedge clk);
        chk("life_still_valid", bus.occupancy, 1);
        @(negedge clk);
        chk("life_expired", bus.occupancy, 0);
        query(PX, 6'd20);
        chk("expired_rejected", bus.rejected, 1);
        @(negedge clk);
        interest(PY, 6'd33);
        chk("y_alloc", bus.fib_out_bit, 1);
        @(negedge clk);
        query(PY, 6'd33);
        chk("y_start", bus.start_send_to_pit, 1);
        @(negedge clk);
        bus.fib_data = pat(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.fib_data = pat(k + 1);
        end
        chk("y_streaming", {bus.data_out_valid, bus.data_out}, {55'd0, 1'b1, pat(4)});
        rst = 1'b1;
        #1;
        chk("abort_data", {bus.data_out_valid, bus.data_last, bus.data_out}, 0);
        chk("abort_occ", bus.occupancy, 0);
        chk("abort_ready", bus.int_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_data", {bus.data_out_valid, bus.data_last}, 0);
        query(PY, 6'd33);
        chk("abort_entry_gone", bus.rejected, 1);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
